propagate_literal_set: RTL and testbench
========================================

// Module: propagate_literal_set
// PURPOSE
//  Multi-literal successor of the single-literal unit-propagation engine in the SAT datapath.
//  Applies up to NUM_ASSIGN literals to a clause-array formula in one pass, one clause per cycle.
//  Removes satisfied clauses and falsified literals, compacts the survivors, and reports conflict,
//  empty formula and the first unit clause. The DPLL controller uses that unit clause for the
//  next BCP step.
// PARAMETERS
//  MAX_CLAUSES  16  clause slots in the formula
//  MAX_LITS      8  literal slots per clause
//  VAR_W         6  variable-index width; literal = {val(1), num(VAR_W)}; num==0 is an unused slot
//  NUM_ASSIGN    4  literal slots applied per pass
//  Derived: LW=VAR_W+1, CW=$clog2(MAX_CLAUSES+1), KW=$clog2(MAX_LITS+1)
// PORTS
//  clock           in   1                          rising-edge clock
//  reset           in   1                          asynchronous, active-low reset
//  start           in   1                          request pass; sampled only when busy==0
//  abort           in   1                          cancel running pass
//  in_lits         in   NUM_ASSIGN*LW              literals to apply; num==0 slots ignored
//  in_lits_cl      in   MAX_CLAUSES*MAX_LITS*LW    clause literal array, clause i slot j
//  in_cl_len       in   MAX_CLAUSES*KW             per-clause length
//  in_f_len        in   CW                         number of valid clauses
//  busy            out  1                          pass in progress
//  done            out  1                          one-cycle completion pulse
//  empty_clause    out  1                          conflict: a clause lost all literals
//  conflict_idx    out  CW                         input index of the conflicting clause
//  empty_formula   out  1                          no clauses survived, no conflict
//  unit_found      out  1                          a surviving clause has exactly one literal
//  unit_lit        out  LW                         literal of the first such clause
//  out_lits_cl     out  MAX_CLAUSES*MAX_LITS*LW    compacted result formula
//  out_cl_len      out  MAX_CLAUSES*KW             result per-clause lengths
//  out_f_len       out  CW                         result clause count
// BEHAVIOUR
//  - Reset (reset==0, async): every output, state and working register is 0; state IDLE.
//  - States: IDLE -> SCAN -> IDLE. No other states.
//  - Accepting a pass:
//    - In IDLE, start==1 captures all inputs and sets busy=1 and clause index i=0.
//    - The same edge clears the working formula, the unit and conflict flags, and the count.
//    - start while busy is ignored.
//  - SCAN, one clause per edge, clause i:
//    - Satisfied: some slot j<len has num!=0 and matches an applied literal in num and val.
//      The clause is dropped; i increments.
//    - Otherwise: keep slots where num!=0 and no applied literal has the same num, in order,
//      packed from slot 0. Unused output slots are 0.
//    - Kept count 0 gives a conflict. On that edge: empty_clause=1, conflict_idx=i,
//      empty_formula=0, done=1, busy=0, go to IDLE.
//      out_* then carries the clauses compacted before i.
//    - Kept count >=1: written at output slot out_f_len, which then increments.
//    - The first kept clause with count 1 sets unit_found=1 and unit_lit. Later units are ignored.
//  - Pass end, on the edge where i reaches in_f_len (including in_f_len==0):
//    - done=1, busy=0, go to IDLE.
//    - empty_formula=1 iff out_f_len==0.
//  - Latency from the start edge:
//    - Done appears max(in_f_len,1) edges later.
//    - On a conflict at clause k, done appears k+1 edges later.
//  - Output lifetime:
//    - done is high for exactly one cycle.
//    - Result outputs hold until the next accepted start, which clears them.
//  - Applied literals with the same num and opposite val:
//    - Both take part in the match; the clause is satisfied if either matches.
//    - No separate detection.
//  - in_cl_len > MAX_LITS is clamped to MAX_LITS. in_f_len > MAX_CLAUSES is clamped.
//  - abort in SCAN: the next edge goes to IDLE with busy=0, done=0, flags 0, outputs zeroed.
//    abort in IDLE has no effect.
//  - Simultaneous start and abort in IDLE: start wins.
//  - reset mid-pass: immediate return to the reset state; no done.
// TESTING
//  1. Formula (1 v -2)(2 v 3), f_len=2, apply {+1}.
//     -> done 2 cycles after start; out = (2 v 3); out_f_len=1; unit_found=0.
//  2. Formula (1 v -2)(2)(-1 v 3), apply {-1,+2}.
//     -> conflict at clause 0 after the first clause; empty_clause=1, conflict_idx=0, done after 1 edge.
//  3. Formula (1)(2 v 3), apply {+1,+2}.
//     -> out_f_len=0, empty_formula=1, empty_clause=0.
//  4. Formula (-4 v 5)(3 v 6), apply {+4, slots num=0}.
//     -> out = (5)(3 v 6); unit_found=1, unit_lit=+5.
//  5. f_len=0 -> done after 1 edge, empty_formula=1.
//     A start pulse while busy -> ignored, with no extra done.
//  6. Abort on the 2nd SCAN edge of a 5-clause pass -> busy=0, no done, outputs 0.
//     Async reset low mid-pass -> all outputs 0 at once.

Source files
------------

// File: rtl/propagate_literal_set.sv
// Multi-literal unit-propagation pass: applies a set of literals to a clause array, one clause
// per cycle, compacting survivors and reporting conflict, empty formula and the first unit clause.
module propagate_literal_set #(
    parameter int unsigned MAX_CLAUSES = 16,
    parameter int unsigned MAX_LITS    = 8,
    parameter int unsigned VAR_W       = 6,
    parameter int unsigned NUM_ASSIGN  = 4,
    localparam int unsigned LW = VAR_W + 1,
    localparam int unsigned CW = $clog2(MAX_CLAUSES + 1),
    localparam int unsigned KW = $clog2(MAX_LITS + 1)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                abort,
    input  logic [NUM_ASSIGN*LW-1:0]            in_lits,
    input  logic [MAX_CLAUSES*MAX_LITS*LW-1:0]  in_lits_cl,
    input  logic [MAX_CLAUSES*KW-1:0]           in_cl_len,
    input  logic [CW-1:0]                       in_f_len,
    output logic                                busy,
    output logic                                done,
    output logic                                empty_clause,
    output logic [CW-1:0]                       conflict_idx,
    output logic                                empty_formula,
    output logic                                unit_found,
    output logic [LW-1:0]                       unit_lit,
    output logic [MAX_CLAUSES*MAX_LITS*LW-1:0]  out_lits_cl,
    output logic [MAX_CLAUSES*KW-1:0]           out_cl_len,
    output logic [CW-1:0]                       out_f_len
);

    localparam int unsigned IW = (MAX_CLAUSES > 1) ? $clog2(MAX_CLAUSES) : 1;
    localparam int unsigned JW = (MAX_LITS > 1) ? $clog2(MAX_LITS) : 1;

    typedef enum logic {StIdle = 1'b0, StScan = 1'b1} state_e;

    state_e         r_state;
    logic           r_busy;
    logic           r_done;
    logic           r_empty_clause;
    logic           r_empty_formula;
    logic           r_unit_found;
    logic [LW-1:0]  r_unit_lit;
    logic [CW-1:0]  r_conflict_idx;
    logic [CW-1:0]  r_i;
    logic [CW-1:0]  r_f_len;
    logic [CW-1:0]  r_out_f_len;
    logic [LW-1:0]  r_lits     [NUM_ASSIGN];
    logic [LW-1:0]  r_cl       [MAX_CLAUSES][MAX_LITS];
    logic [KW-1:0]  r_cl_len   [MAX_CLAUSES];
    logic [LW-1:0]  r_out_cl   [MAX_CLAUSES][MAX_LITS];
    logic [KW-1:0]  r_out_len  [MAX_CLAUSES];

    logic [LW-1:0]  w_in_lits    [NUM_ASSIGN];
    logic [LW-1:0]  w_in_cl      [MAX_CLAUSES][MAX_LITS];
    logic [KW-1:0]  w_in_cl_len  [MAX_CLAUSES];

    logic [IW-1:0]  w_idx;
    logic [IW-1:0]  w_out_idx;
    logic [KW-1:0]  w_len_raw;
    logic [KW-1:0]  w_len;
    logic [LW-1:0]  w_lit;
    logic [LW-1:0]  w_app;
    logic           w_hit_num;
    logic           w_hit_lit;
    logic           w_sat;
    logic [KW-1:0]  w_cnt;
    logic [LW-1:0]  w_kept [MAX_LITS];
    logic           w_conflict;
    logic [CW-1:0]  w_next_f_len;
    logic           w_last;
    logic           w_clear;

    for (genvar a = 0; a < NUM_ASSIGN; a++) begin : g_in_lits
        assign w_in_lits[a] = in_lits[a*LW +: LW];
    end

    for (genvar c = 0; c < MAX_CLAUSES; c++) begin : g_cl
        assign w_in_cl_len[c]       = in_cl_len[c*KW +: KW];
        assign out_cl_len[c*KW +: KW] = r_out_len[c];
        for (genvar l = 0; l < MAX_LITS; l++) begin : g_lit
            assign w_in_cl[c][l]                          = in_lits_cl[(c*MAX_LITS+l)*LW +: LW];
            assign out_lits_cl[(c*MAX_LITS+l)*LW +: LW]   = r_out_cl[c][l];
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign empty_clause  = r_empty_clause;
    assign conflict_idx  = r_conflict_idx;
    assign empty_formula = r_empty_formula;
    assign unit_found    = r_unit_found;
    assign unit_lit      = r_unit_lit;
    assign out_f_len     = r_out_f_len;

    assign w_idx     = r_i[IW-1:0];
    assign w_out_idx = r_out_f_len[IW-1:0];
    assign w_len_raw = r_cl_len[w_idx];
    assign w_len     = (w_len_raw > KW'(MAX_LITS)) ? KW'(MAX_LITS) : w_len_raw;

    // Evaluate clause r_i against every applied literal and pack surviving slots from 0.
    always_comb begin
        w_lit     = '0;
        w_app     = '0;
        w_hit_num = 1'b0;
        w_hit_lit = 1'b0;
        w_sat     = 1'b0;
        w_cnt     = '0;
        for (int k = 0; k < MAX_LITS; k++) begin
            w_kept[k] = '0;
        end
        for (int j = 0; j < MAX_LITS; j++) begin
            w_lit     = r_cl[w_idx][j];
            w_hit_num = 1'b0;
            w_hit_lit = 1'b0;
            for (int a = 0; a < NUM_ASSIGN; a++) begin
                w_app = r_lits[a];
                if (w_app[VAR_W-1:0] != '0 && w_app[VAR_W-1:0] == w_lit[VAR_W-1:0]) begin
                    w_hit_num = 1'b1;
                    if (w_app[VAR_W] == w_lit[VAR_W]) begin
                        w_hit_lit = 1'b1;
                    end
                end
            end
            if (j < int'(w_len) && w_lit[VAR_W-1:0] != '0) begin
                if (w_hit_lit) begin
                    w_sat = 1'b1;
                end
                if (!w_hit_num) begin
                    w_kept[w_cnt[JW-1:0]] = w_lit;
                    w_cnt = w_cnt + KW'(1);
                end
            end
        end
    end

    assign w_conflict   = !w_sat && (w_cnt == '0);
    assign w_next_f_len = w_sat ? r_out_f_len : r_out_f_len + CW'(1);
    assign w_last       = (r_i + CW'(1)) == r_f_len;
    assign w_clear      = ((r_state == StIdle) && start) || ((r_state == StScan) && abort);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= StIdle;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_empty_clause  <= 1'b0;
            r_empty_formula <= 1'b0;
            r_unit_found    <= 1'b0;
            r_unit_lit      <= '0;
            r_conflict_idx  <= '0;
            r_i             <= '0;
            r_f_len         <= '0;
            r_out_f_len     <= '0;
            for (int a = 0; a < NUM_ASSIGN; a++) begin
                r_lits[a] <= '0;
            end
            for (int c = 0; c < MAX_CLAUSES; c++) begin
                r_cl_len[c]  <= '0;
                r_out_len[c] <= '0;
                for (int l = 0; l < MAX_LITS; l++) begin
                    r_cl[c][l]     <= '0;
                    r_out_cl[c][l] <= '0;
                end
            end
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state  <= StScan;
                        r_busy   <= 1'b1;
                        r_i      <= '0;
                        r_lits   <= w_in_lits;
                        r_cl     <= w_in_cl;
                        r_cl_len <= w_in_cl_len;
                        r_f_len  <= (in_f_len > CW'(MAX_CLAUSES)) ? CW'(MAX_CLAUSES) : in_f_len;
                    end
                end
                StScan: begin
                    if (abort) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else if (r_i >= r_f_len) begin
                        // Only reachable for an empty input formula.
                        r_state         <= StIdle;
                        r_busy          <= 1'b0;
                        r_done          <= 1'b1;
                        r_empty_formula <= (r_out_f_len == '0);
                    end else if (w_conflict) begin
                        r_state         <= StIdle;
                        r_busy          <= 1'b0;
                        r_done          <= 1'b1;
                        r_empty_clause  <= 1'b1;
                        r_conflict_idx  <= r_i;
                        r_empty_formula <= 1'b0;
                    end else begin
                        if (!w_sat) begin
                            r_out_cl[w_out_idx]  <= w_kept;
                            r_out_len[w_out_idx] <= w_cnt;
                            r_out_f_len          <= w_next_f_len;
                            if (w_cnt == KW'(1) && !r_unit_found) begin
                                r_unit_found <= 1'b1;
                                r_unit_lit   <= w_kept[0];
                            end
                        end
                        r_i <= r_i + CW'(1);
                        if (w_last) begin
                            r_state         <= StIdle;
                            r_busy          <= 1'b0;
                            r_done          <= 1'b1;
                            r_empty_formula <= (w_next_f_len == '0);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
            // Placed last so it overrides any result update on a start or abort edge.
            if (w_clear) begin
                r_empty_clause  <= 1'b0;
                r_empty_formula <= 1'b0;
                r_unit_found    <= 1'b0;
                r_unit_lit      <= '0;
                r_conflict_idx  <= '0;
                r_out_f_len     <= '0;
                for (int c = 0; c < MAX_CLAUSES; c++) begin
                    r_out_len[c] <= '0;
                    for (int l = 0; l < MAX_LITS; l++) begin
                        r_out_cl[c][l] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_propagate_literal_set.sv
// Directed bench for propagate_literal_set: expected results are queued when a pass is started
// and compared against the DUT outputs when done pulses.
module tb_propagate_literal_set;

    localparam int MC = 16;
    localparam int ML = 8;
    localparam int VW = 6;
    localparam int NA = 4;
    localparam int LW = VW + 1;
    localparam int CW = 5;
    localparam int KW = 4;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   start;
    logic                   abort;
    logic [NA*LW-1:0]       in_lits;
    logic [MC*ML*LW-1:0]    in_lits_cl;
    logic [MC*KW-1:0]       in_cl_len;
    logic [CW-1:0]          in_f_len;
    logic                   busy;
    logic                   done;
    logic                   empty_clause;
    logic [CW-1:0]          conflict_idx;
    logic                   empty_formula;
    logic                   unit_found;
    logic [LW-1:0]          unit_lit;
    logic [MC*ML*LW-1:0]    out_lits_cl;
    logic [MC*KW-1:0]       out_cl_len;
    logic [CW-1:0]          out_f_len;

    propagate_literal_set dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .in_lits       (in_lits),
        .in_lits_cl    (in_lits_cl),
        .in_cl_len     (in_cl_len),
        .in_f_len      (in_f_len),
        .busy          (busy),
        .done          (done),
        .empty_clause  (empty_clause),
        .conflict_idx  (conflict_idx),
        .empty_formula (empty_formula),
        .unit_found    (unit_found),
        .unit_lit      (unit_lit),
        .out_lits_cl   (out_lits_cl),
        .out_cl_len    (out_cl_len),
        .out_f_len     (out_f_len)
    );

    always #5 clock = ~clock;

    typedef struct {
        int                  lat;
        logic                ec;
        logic [CW-1:0]       ci;
        logic                ef;
        logic                uf;
        logic [LW-1:0]       ul;
        logic [CW-1:0]       fl;
        logic [MC*ML*LW-1:0] cl;
        logic [MC*KW-1:0]    len;
    } exp_t;

    exp_t sb[$];
    exp_t e_cur;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [LW-1:0] lit(input int v);
        logic [LW-1:0] r;
        if (v < 0) r = {1'b0, VW'(-v)};
        else       r = {1'b1, VW'(v)};
        return r;
    endfunction

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        in_lits    = '0;
        in_lits_cl = '0;
        in_cl_len  = '0;
        in_f_len   = '0;
    endtask

    task automatic put_cl(input int c, input int s, input int v);
        in_lits_cl[(c*ML+s)*LW +: LW] = lit(v);
    endtask

    task automatic put_len(input int c, input int n);
        in_cl_len[c*KW +: KW] = KW'(n);
    endtask

    task automatic put_app(input int a, input int v);
        in_lits[a*LW +: LW] = lit(v);
    endtask

    task automatic exp_new(input int lat);
        e_cur.lat = lat;
        e_cur.ec  = 1'b0;
        e_cur.ci  = '0;
        e_cur.ef  = 1'b0;
        e_cur.uf  = 1'b0;
        e_cur.ul  = '0;
        e_cur.fl  = '0;
        e_cur.cl  = '0;
        e_cur.len = '0;
    endtask

    task automatic exp_cl(input int c, input int s, input int v);
        e_cur.cl[(c*ML+s)*LW +: LW] = lit(v);
    endtask

    task automatic exp_len(input int c, input int n);
        e_cur.len[c*KW +: KW] = KW'(n);
    endtask

    // Start a pass, wait (bounded) for done, then compare against the oldest queued result.
    task automatic run_pass(input string nm, input logic ab);
        exp_t e;
        int   cyc;
        @(negedge clock);
        start = 1'b1;
        abort = ab;
        @(posedge clock);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check({nm, "/busy_after_start"}, busy, 1'b1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        e = sb.pop_front();
        check({nm, "/latency"}, cyc, e.lat);
        check({nm, "/busy"}, busy, 1'b0);
        check({nm, "/empty_clause"}, empty_clause, e.ec);
        check({nm, "/conflict_idx"}, conflict_idx, e.ci);
        check({nm, "/empty_formula"}, empty_formula, e.ef);
        check({nm, "/unit_found"}, unit_found, e.uf);
        check({nm, "/unit_lit"}, unit_lit, e.ul);
        check({nm, "/out_f_len"}, out_f_len, e.fl);
        check({nm, "/out_lits_cl"}, out_lits_cl, e.cl);
        check({nm, "/out_cl_len"}, out_cl_len, e.len);
        @(posedge clock);
        #1;
        check({nm, "/done_pulse"}, done, 1'b0);
        check({nm, "/hold_f_len"}, out_f_len, e.fl);
        check({nm, "/hold_lits_cl"}, out_lits_cl, e.cl);
    endtask

    // Five-clause formula: first clause is a unit, nothing gets satisfied by {+7}.
    task automatic load_five();
        clear_in();
        put_cl(0, 0, 5);  put_len(0, 1);
        put_cl(1, 0, 1);  put_cl(1, 1, 2);  put_len(1, 2);
        put_cl(2, 0, -1); put_cl(2, 1, 3);  put_len(2, 2);
        put_cl(3, 0, 4);  put_cl(3, 1, -5); put_len(3, 2);
        put_cl(4, 0, 6);  put_cl(4, 1, 2);  put_len(4, 2);
        in_f_len = 5;
        put_app(0, 7);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int at;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        clear_in();
        #2;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset/busy", busy, 1'b0);
        check("reset/done", done, 1'b0);
        check("reset/out_f_len", out_f_len, '0);
        check("reset/out_lits_cl", out_lits_cl, '0);
        check("reset/flags", {empty_clause, empty_formula, unit_found}, 3'b000);
        @(negedge clock);
        reset = 1'b1;

        // (1 v -2)(2 v 3) with {+1}: first clause satisfied, second survives intact.
        clear_in();
        put_cl(0, 0, 1); put_cl(0, 1, -2); put_len(0, 2);
        put_cl(1, 0, 2); put_cl(1, 1, 3);  put_len(1, 2);
        in_f_len = 2;
        put_app(0, 1);
        exp_new(2);
        e_cur.fl = 1;
        exp_cl(0, 0, 2); exp_cl(0, 1, 3); exp_len(0, 2);
        sb.push_back(e_cur);
        run_pass("t1", 1'b0);

        // (1 v -2)(2)(-1 v 3) with {-1,+2}: clause 0 loses both literals.
        clear_in();
        put_cl(0, 0, 1);  put_cl(0, 1, -2); put_len(0, 2);
        put_cl(1, 0, 2);  put_len(1, 1);
        put_cl(2, 0, -1); put_cl(2, 1, 3);  put_len(2, 2);
        in_f_len = 3;
        put_app(0, -1); put_app(1, 2);
        exp_new(1);
        e_cur.ec = 1'b1;
        e_cur.ci = 0;
        sb.push_back(e_cur);
        run_pass("t2", 1'b0);

        // (5)(6)(-7) with {+7}: conflict at clause 2 after two survivors.
        clear_in();
        put_cl(0, 0, 5);  put_len(0, 1);
        put_cl(1, 0, 6);  put_len(1, 1);
        put_cl(2, 0, -7); put_len(2, 1);
        in_f_len = 3;
        put_app(2, 7);
        exp_new(3);
        e_cur.ec = 1'b1;
        e_cur.ci = 2;
        e_cur.uf = 1'b1;
        e_cur.ul = lit(5);
        e_cur.fl = 2;
        exp_cl(0, 0, 5); exp_len(0, 1);
        exp_cl(1, 0, 6); exp_len(1, 1);
        sb.push_back(e_cur);
        run_pass("t2b", 1'b0);

        // (1)(2 v 3) with {+1,+2}, abort raised together with start (start wins).
        clear_in();
        put_cl(0, 0, 1); put_len(0, 1);
        put_cl(1, 0, 2); put_cl(1, 1, 3); put_len(1, 2);
        in_f_len = 2;
        put_app(0, 1); put_app(1, 2);
        exp_new(2);
        e_cur.ef = 1'b1;
        sb.push_back(e_cur);
        run_pass("t3", 1'b1);

        // (-4 v 5)(3 v 6) with {+4}: first survivor becomes unit +5.
        clear_in();
        put_cl(0, 0, -4); put_cl(0, 1, 5); put_len(0, 2);
        put_cl(1, 0, 3);  put_cl(1, 1, 6); put_len(1, 2);
        in_f_len = 2;
        put_app(0, 4);
        exp_new(2);
        e_cur.uf = 1'b1;
        e_cur.ul = lit(5);
        e_cur.fl = 2;
        exp_cl(0, 0, 5); exp_len(0, 1);
        exp_cl(1, 0, 3); exp_cl(1, 1, 6); exp_len(1, 2);
        sb.push_back(e_cur);
        run_pass("t4", 1'b0);

        // (3 v 4) with both +3 and -3 applied: satisfied through +3.
        clear_in();
        put_cl(0, 0, 3); put_cl(0, 1, 4); put_len(0, 2);
        in_f_len = 1;
        put_app(0, 3); put_app(3, -3);
        exp_new(1);
        e_cur.ef = 1'b1;
        sb.push_back(e_cur);
        run_pass("t_opp", 1'b0);

        // Empty input formula.
        clear_in();
        exp_new(1);
        e_cur.ef = 1'b1;
        sb.push_back(e_cur);
        run_pass("t5_empty", 1'b0);

        // f_len 20 clamps to 16 clauses; lengths 15 clamp to 8 slots.
        clear_in();
        for (int c = 0; c < MC; c++) begin
            put_cl(c, 0, c + 1);
            put_len(c, 15);
        end
        in_f_len = 20;
        exp_new(16);
        e_cur.uf = 1'b1;
        e_cur.ul = lit(1);
        e_cur.fl = 16;
        for (int c = 0; c < MC; c++) begin
            exp_cl(c, 0, c + 1);
            exp_len(c, 1);
        end
        sb.push_back(e_cur);
        run_pass("t_clamp", 1'b0);

        // Start pulse while busy must not produce a second done.
        clear_in();
        put_cl(0, 0, 1); put_cl(0, 1, -2); put_len(0, 2);
        put_cl(1, 0, 2); put_cl(1, 1, 3);  put_len(1, 2);
        in_f_len = 2;
        put_app(0, 1);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        start = 1'b1;
        nd = 0;
        at = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) start = 1'b0;
            if (done === 1'b1) begin
                nd++;
                at = k;
            end
        end
        check("t5_busy/done_count", nd, 1);
        check("t5_busy/done_edge", at, 2);
        check("t5_busy/out_f_len", out_f_len, 5'd1);

        // Abort on the second SCAN edge of a five-clause pass.
        load_five();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        check("t6_abort/mid_f_len", out_f_len, 5'd1);
        check("t6_abort/mid_unit", {unit_found, unit_lit}, {1'b1, lit(5)});
        @(negedge clock);
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        check("t6_abort/busy", busy, 1'b0);
        check("t6_abort/done", done, 1'b0);
        check("t6_abort/out_f_len", out_f_len, '0);
        check("t6_abort/out_lits_cl", out_lits_cl, '0);
        check("t6_abort/out_cl_len", out_cl_len, '0);
        check("t6_abort/unit", {unit_found, unit_lit}, '0);
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) nd++;
        end
        check("t6_abort/no_done", nd, 0);

        // Asynchronous reset mid-pass clears outputs without waiting for an edge.
        load_five();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("t6_reset/busy", busy, 1'b0);
        check("t6_reset/out_f_len", out_f_len, '0);
        check("t6_reset/out_lits_cl", out_lits_cl, '0);
        check("t6_reset/unit", {unit_found, unit_lit}, '0);
        @(negedge clock);
        reset = 1'b1;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) nd++;
        end
        check("t6_reset/no_done", nd, 0);
        check("t6_reset/idle_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
